spi_master: RTL

- SPI mode-0 initiator that drives frames into the existing SPI slave register block.
- Frame format: 8-bit command then 32-bit data on mosi, MSB first. The slave returns an 8-bit status then 32-bit data on miso.
- Host logic loads the command and data words and pulses start. The block generates sck, ncs and mosi from the system clock, then returns the captured status and data with a done pulse.

---
 rtl/spi_master.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/spi_master.sv
// spi_master: SPI mode-0 initiator sending an 8-bit command and 32-bit data word.
// Define SPI_MASTER_SHORT_EN to add cmd_only for 8-bit command-only frames.
module spi_master #(
    parameter int CLK_DIV = 8,
    parameter int CS_GAP  = 4
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        start,
    input  logic [7:0]  cmd_in,
    input  logic [31:0] data_in,
`ifdef SPI_MASTER_SHORT_EN
    input  logic        cmd_only,
`endif
    output logic        busy,
    output logic        done,
    output logic [7:0]  stat_out,
    output logic [31:0] data_out,
    output logic        sck,
    output logic        mosi,
    output logic        ncs,
    input  logic        miso
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        HOLD,
        GAP
    } state_t;

    state_t      state;
    logic [15:0] div_cnt;
    logic [5:0]  bit_cnt;
    logic [5:0]  nbits;
    logic [38:0] tx;
    logic [39:0] rx;
    logic        div_last;
    logic        gap_last;
    logic        last_bit;

`ifdef SPI_MASTER_SHORT_EN
    logic short_q;
    assign nbits = short_q ? 6'd8 : 6'd40;
`else
    assign nbits = 6'd40;
`endif

    assign div_last = (div_cnt == 16'(CLK_DIV - 1));
    assign gap_last = (div_cnt == 16'(CS_GAP - 1));
    assign last_bit = ((bit_cnt + 6'd1) == nbits);

    // tx holds only the bits still to be sent; the current bit sits in mosi.
    always_ff @(posedge clk) begin
        done <= 1'b0;
        if (!nrst) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            tx       <= '0;
            rx       <= '0;
            busy     <= 1'b0;
            sck      <= 1'b0;
            mosi     <= 1'b0;
            ncs      <= 1'b1;
            stat_out <= '0;
            data_out <= '0;
`ifdef SPI_MASTER_SHORT_EN
            short_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        tx      <= {cmd_in[6:0], data_in};
                        mosi    <= cmd_in[7];
                        busy    <= 1'b1;
                        ncs     <= 1'b0;
                        div_cnt <= '0;
                        bit_cnt <= '0;
`ifdef SPI_MASTER_SHORT_EN
                        short_q <= cmd_only;
`endif
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        sck     <= 1'b1;
                        state   <= HIGH;
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end
                HIGH: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        sck     <= 1'b0;
                        rx      <= {rx[38:0], miso};
                        bit_cnt <= bit_cnt + 6'd1;
                        if (!last_bit) begin
                            tx   <= {tx[37:0], 1'b0};
                            mosi <= tx[38];
                        end
                        state   <= LOW;
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end
                // Every bit, the last included, gets a full low phase.
                LOW: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        if (bit_cnt == nbits) begin
                            state <= HOLD;
                        end else begin
                            sck   <= 1'b1;
                            state <= HIGH;
                        end
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end
                HOLD: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        ncs     <= 1'b1;
                        mosi    <= 1'b0;
                        state   <= GAP;
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end
                GAP: begin
                    if (gap_last) begin
                        div_cnt <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
`ifdef SPI_MASTER_SHORT_EN
                        stat_out <= short_q ? rx[7:0] : rx[39:32];
                        if (!short_q) begin
                            data_out <= rx[31:0];
                        end
`else
                        stat_out <= rx[39:32];
                        data_out <= rx[31:0];
`endif
                        state   <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
